vending_ctrl_param: RTL and testbench
=====================================

// Module: vending_ctrl_param
// PURPOSE
//  Parametrised vending core: N_ITEMS products, per-item price, per-item stock counters,
//  credit accumulator, vend handshake, timed change return and inactivity auto-refund.
//  Sits between the button/switch decoder (single-cycle strobes) and the 7-seg display driver;
//  all money values in half-yuan units (1 = 5 jiao, 2 = 1 yuan).
// PARAMETERS
//  N_ITEMS     3           number of products
//  ID_W        2           width of product index (2**ID_W >= N_ITEMS)
//  PRICE_W     5           width of one price field
//  PRICES      {5'd4,5'd5,5'd6}  packed prices, item0 at LSBs (item0=6, item1=5, item2=4)
//  CREDIT_W    6           credit width
//  CREDIT_MAX  20          coin rejected if credit+value would exceed this
//  STOCK_W     4           stock counter width
//  STOCK_INIT  5           stock per item after reset
//  STOCK_MAX   15          stock per item after fill_up
//  CHANGE_GAP  4           cycles between change_pulse strobes (>=2)
//  TIMEOUT     1000        idle cycles in CREDIT before auto-refund
// PORTS
//  clk           in   1         system clock
//  rst_n         in   1         asynchronous reset, active low
//  coin_half     in   1         strobe: 5 jiao inserted (+1)
//  coin_one      in   1         strobe: 1 yuan inserted (+2)
//  sel           in   N_ITEMS   strobe: product select, lowest set bit wins
//  refund        in   1         strobe: return all credit
//  fill_up       in   1         strobe: restock all items to STOCK_MAX
//  inq_id        in   ID_W      product to report on stock_q
//  vend_ack      in   1         dispenser accepted vend request
//  credit        out  CREDIT_W  current credit
//  vend_valid    out  1         vend request pending
//  vend_id       out  ID_W      product being vended
//  change_pulse  out  1         strobe: one half-yuan returned
//  coin_reject   out  1         strobe: coin returned, not credited
//  err_empty     out  1         strobe: selected item stock is 0
//  err_funds     out  1         strobe: credit below price
//  stock_q       out  STOCK_W   stock of inq_id, registered (1-cycle latency)
//  busy          out  1         high in VEND or CHANGE
// BEHAVIOUR
//  Reset: state IDLE, credit=0, all stock=STOCK_INIT, every output 0; in-flight vend/change lost.
//  States: IDLE (credit==0), CREDIT, VEND, CHANGE. All strobe outputs are 1-cycle pulses.
//  Coins accepted in IDLE/CREDIT only: credit+=value next cycle, IDLE->CREDIT; if over CREDIT_MAX
//   or in VEND/CHANGE -> coin_reject, credit unchanged. Both coins same cycle: coin_one first,
//   coin_half then evaluated against updated sum; each may reject independently.
//  CREDIT, priority refund > sel > coin; sel/refund judged on pre-coin credit; same-cycle
//   accepted coin still added. refund -> CHANGE. sel item i (i<N_ITEMS else ignored):
//   stock[i]==0 -> err_empty, stay; credit<PRICE[i] -> err_funds, stay; else -> VEND.
//  sel in IDLE: err_funds (or err_empty if stock 0), stay IDLE.
//  VEND: vend_valid=1, vend_id=i held stable until vend_ack sampled high; on ack cycle
//   credit-=PRICE[i], stock[i]-=1, vend_valid drops next cycle; ->CHANGE if remainder>0 else IDLE.
//  CHANGE: first change_pulse 1 cycle after entry, then every CHANGE_GAP cycles, credit-=1 each;
//   ->IDLE on cycle credit reaches 0. sel/refund/fill_up ignored.
//  Timeout counter: cleared on any coin/sel/refund; in CREDIT reaching TIMEOUT -> CHANGE.
//  fill_up honoured in IDLE only; stock never decrements below 0 nor exceeds STOCK_MAX.
//  Arithmetic unsigned; credit compare done in CREDIT_W+1 bits (no wrap).
// TESTING
//  reset, coin_one x3 -> credit 6; sel=001 -> vend_valid, vend_id=0; ack -> credit 0, stock0 4, IDLE.
//  coin_one x4 (8), sel=100 -> vend id2; ack -> credit 4; 4 change_pulse CHANGE_GAP apart -> IDLE.
//  credit 19, coin_one -> coin_reject, credit 19; coin_half -> credit 20.
//  credit 2, sel=010 -> err_funds, credit 2; stock1 drained to 0, sel=010 -> err_empty.
//  credit 3, no activity 1000 cycles -> 3 change_pulse, IDLE; rst_n low during VEND -> all cleared.
//  fill_up in CREDIT ignored; in IDLE -> stock_q for inq_id=0..2 reads 15 one cycle after.

Source files
------------

// File: rtl/vending_ctrl_param_if.sv
// Strobe/handshake bundle between the button decoder, the vending core and the display/dispenser side.
// The master drives the strobes and the ack; the slave (vending core) drives status and pulses back.
interface vending_ctrl_param_if #(
    parameter int N_ITEMS  = 3,
    parameter int ID_W     = 2,
    parameter int CREDIT_W = 6,
    parameter int STOCK_W  = 4
);
    logic                coin_half;
    logic                coin_one;
    logic [N_ITEMS-1:0]  sel;
    logic                refund;
    logic                fill_up;
    logic [ID_W-1:0]     inq_id;
    logic                vend_ack;

    logic [CREDIT_W-1:0] credit;
    logic                vend_valid;
    logic [ID_W-1:0]     vend_id;
    logic                change_pulse;
    logic                coin_reject;
    logic                err_empty;
    logic                err_funds;
    logic [STOCK_W-1:0]  stock_q;
    logic                busy;

    modport master (
        output coin_half, coin_one, sel, refund, fill_up, inq_id, vend_ack,
        input  credit, vend_valid, vend_id, change_pulse, coin_reject,
               err_empty, err_funds, stock_q, busy
    );

    modport slave (
        input  coin_half, coin_one, sel, refund, fill_up, inq_id, vend_ack,
        output credit, vend_valid, vend_id, change_pulse, coin_reject,
               err_empty, err_funds, stock_q, busy
    );
endinterface

// File: rtl/vending_ctrl_param.sv
// Vending core: credit accumulation, per-item stock, vend handshake, paced change return
// and inactivity auto-refund. Money is counted in half-yuan units.
module vending_ctrl_param #(
    parameter int N_ITEMS    = 3,
    parameter int ID_W       = 2,
    parameter int PRICE_W    = 5,
    parameter logic [N_ITEMS*PRICE_W-1:0] PRICES = {5'd4, 5'd5, 5'd6},
    parameter int CREDIT_W   = 6,
    parameter int CREDIT_MAX = 20,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 5,
    parameter int STOCK_MAX  = 15,
    parameter int CHANGE_GAP = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vending_ctrl_param_if.slave   bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CREDIT = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_CHANGE = 2'd3;

    localparam int CW1   = CREDIT_W + 1;
    localparam int GAP_W = $clog2(CHANGE_GAP);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [ID_W-1:0]     vend_id_q, vend_id_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [TO_W-1:0]     idle_q, idle_d;
    logic                change_pulse_q, change_pulse_d;
    logic                coin_reject_q, coin_reject_d;
    logic                err_empty_q, err_empty_d;
    logic                err_funds_q, err_funds_d;
    logic [STOCK_W-1:0]  stock_out_q;

    logic [STOCK_W-1:0]  stock_arr [N_ITEMS];
    logic [PRICE_W-1:0]  price_arr [N_ITEMS];

    logic                fill_en;
    logic                sel_hit;
    logic [ID_W-1:0]     sel_idx;
    logic                sel_empty, sel_poor;
    logic                coin_en, one_ok, half_ok, activity;
    logic [CW1-1:0]      cred_ext, sum1, sum2;
    logic [CREDIT_W-1:0] vend_rem;

    assign fill_en = (state_q == S_IDLE) && bus.fill_up;

    genvar gi;
    generate
        for (gi = 0; gi < N_ITEMS; gi++) begin : g_item
            logic [STOCK_W-1:0] cnt_q;
            logic               dec;

            // Decrement is guarded so an empty slot can never wrap.
            assign dec = (state_q == S_VEND) && bus.vend_ack &&
                         (vend_id_q == ID_W'(gi)) && (cnt_q != '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       cnt_q <= STOCK_W'(STOCK_INIT);
                else if (fill_en) cnt_q <= STOCK_W'(STOCK_MAX);
                else if (dec)     cnt_q <= cnt_q - STOCK_W'(1);
            end

            assign stock_arr[gi] = cnt_q;
            assign price_arr[gi] = PRICES[gi*PRICE_W +: PRICE_W];
        end
    endgenerate

    // Lowest set select bit wins.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            if (bus.sel[i]) begin
                sel_hit = 1'b1;
                sel_idx = ID_W'(i);
            end
        end
    end

    // Coin evaluation in one extra bit so the limit compare cannot wrap; coin_one goes first.
    assign coin_en  = (state_q == S_IDLE) || (state_q == S_CREDIT);
    assign cred_ext = {1'b0, credit_q};
    assign one_ok   = coin_en && bus.coin_one && ((cred_ext + CW1'(2)) <= CW1'(CREDIT_MAX));
    assign sum1     = cred_ext + (one_ok ? CW1'(2) : CW1'(0));
    assign half_ok  = coin_en && bus.coin_half && ((sum1 + CW1'(1)) <= CW1'(CREDIT_MAX));
    assign sum2     = sum1 + (half_ok ? CW1'(1) : CW1'(0));
    assign activity = bus.coin_half || bus.coin_one || bus.refund || sel_hit;

    assign sel_empty = (stock_arr[sel_idx] == '0);
    assign sel_poor  = cred_ext < CW1'(price_arr[sel_idx]);
    assign vend_rem  = credit_q - CREDIT_W'(price_arr[vend_id_q]);

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        vend_id_d      = vend_id_q;
        gap_d          = gap_q;
        idle_d         = '0;
        change_pulse_d = 1'b0;
        err_empty_d    = 1'b0;
        err_funds_d    = 1'b0;
        coin_reject_d  = (bus.coin_one && !one_ok) || (bus.coin_half && !half_ok);

        case (state_q)
            S_IDLE, S_CREDIT: begin
                credit_d = CREDIT_W'(sum2);
                if ((state_q == S_CREDIT) && bus.refund) begin
                    state_d = S_CHANGE;
                    gap_d   = '0;
                end else if (sel_hit) begin
                    if (sel_empty)     err_empty_d = 1'b1;
                    else if (sel_poor) err_funds_d = 1'b1;
                    else begin
                        state_d   = S_VEND;
                        vend_id_d = sel_idx;
                    end
                end else if ((state_q == S_CREDIT) && !activity) begin
                    if (idle_q == TO_W'(TIMEOUT - 1)) begin
                        state_d = S_CHANGE;
                        gap_d   = '0;
                    end else begin
                        idle_d = idle_q + TO_W'(1);
                    end
                end
                if ((state_q == S_IDLE) && (state_d == S_IDLE) && (one_ok || half_ok))
                    state_d = S_CREDIT;
            end
            S_VEND: begin
                if (bus.vend_ack) begin
                    credit_d = vend_rem;
                    gap_d    = '0;
                    state_d  = (vend_rem != '0) ? S_CHANGE : S_IDLE;
                end
            end
            default: begin
                // Payout fires whenever the gap counter is zero; it is zero on entry.
                if (credit_q == '0) begin
                    state_d = S_IDLE;
                end else if (gap_q == '0) begin
                    change_pulse_d = 1'b1;
                    credit_d       = credit_q - CREDIT_W'(1);
                    gap_d          = GAP_W'(CHANGE_GAP - 1);
                    if (credit_q == CREDIT_W'(1)) state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            vend_id_q      <= '0;
            gap_q          <= '0;
            idle_q         <= '0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            err_empty_q    <= 1'b0;
            err_funds_q    <= 1'b0;
            stock_out_q    <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_id_q      <= vend_id_d;
            gap_q          <= gap_d;
            idle_q         <= idle_d;
            change_pulse_q <= change_pulse_d;
            coin_reject_q  <= coin_reject_d;
            err_empty_q    <= err_empty_d;
            err_funds_q    <= err_funds_d;
            stock_out_q    <= (int'(bus.inq_id) < N_ITEMS) ? stock_arr[bus.inq_id] : '0;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.vend_valid   = (state_q == S_VEND);
    assign bus.vend_id      = vend_id_q;
    assign bus.change_pulse = change_pulse_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.err_empty    = err_empty_q;
    assign bus.err_funds    = err_funds_q;
    assign bus.stock_q      = stock_out_q;
    assign bus.busy         = (state_q == S_VEND) || (state_q == S_CHANGE);
endmodule

// File: tb/tb_vending_ctrl_param.sv
// Directed bench for vending_ctrl_param: purchases, change pacing, coin limits,
// error strobes, inactivity refund, asynchronous reset and restocking.
module tb_vending_ctrl_param;
    localparam int N_ITEMS  = 3;
    localparam int ID_W     = 2;
    localparam int CREDIT_W = 6;
    localparam int STOCK_W  = 4;
    localparam int GAP      = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vending_ctrl_param_if #(
        .N_ITEMS(N_ITEMS), .ID_W(ID_W), .CREDIT_W(CREDIT_W), .STOCK_W(STOCK_W)
    ) bus ();

    vending_ctrl_param #(
        .N_ITEMS(N_ITEMS), .ID_W(ID_W), .PRICE_W(5), .PRICES({5'd4, 5'd5, 5'd6}),
        .CREDIT_W(CREDIT_W), .CREDIT_MAX(20), .STOCK_W(STOCK_W), .STOCK_INIT(5),
        .STOCK_MAX(15), .CHANGE_GAP(GAP), .TIMEOUT(1000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin1();
        bus.coin_one = 1'b1; step(); bus.coin_one = 1'b0;
    endtask

    task automatic coinh();
        bus.coin_half = 1'b1; step(); bus.coin_half = 1'b0;
    endtask

    task automatic do_sel(input logic [N_ITEMS-1:0] s);
        bus.sel = s; step(); bus.sel = '0;
    endtask

    task automatic do_ack();
        bus.vend_ack = 1'b1; step(); bus.vend_ack = 1'b0;
    endtask

    task automatic do_refund();
        bus.refund = 1'b1; step(); bus.refund = 1'b0;
    endtask

    // Runs until busy drops (bounded), counting change pulses.
    task automatic drain(output int np);
        np = 0;
        for (int k = 0; k < 400 && bus.busy; k++) begin
            step();
            if (bus.change_pulse) np++;
        end
    endtask

    task automatic read_stock(input int id, output int unsigned v);
        bus.inq_id = ID_W'(id);
        step();
        v = bus.stock_q;
    endtask

    initial begin
        int np;
        int last;
        int unsigned sv;

        bus.coin_half = 0; bus.coin_one = 0; bus.sel = '0; bus.refund = 0;
        bus.fill_up = 0; bus.inq_id = '0; bus.vend_ack = 0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_credit", bus.credit, 0);
        chk("rst_vend_valid", bus.vend_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_stock_q", bus.stock_q, 0);
        rst_n = 1'b1;
        read_stock(0, sv);
        chk("init_stock0", sv, 5);

        // Buy item0 (price 6) with exact credit
        repeat (3) coin1();
        chk("credit_6", bus.credit, 6);
        do_sel(3'b001);
        chk("vend_valid", bus.vend_valid, 1);
        chk("vend_id0", bus.vend_id, 0);
        chk("vend_busy", bus.busy, 1);
        step(); step();
        chk("vend_hold", bus.vend_valid, 1);
        do_ack();
        chk("ack_credit0", bus.credit, 0);
        chk("ack_valid_drop", bus.vend_valid, 0);
        chk("ack_idle", bus.busy, 0);
        read_stock(0, sv);
        chk("stock0_after", sv, 4);

        // Buy item2 (price 4) with 8, expect 4 paced change pulses
        repeat (4) coin1();
        do_sel(3'b100);
        chk("vend_id2", bus.vend_id, 2);
        do_ack();
        chk("rem_credit4", bus.credit, 4);
        chk("chg_busy", bus.busy, 1);
        chk("chg_no_pulse_entry", bus.change_pulse, 0);
        np = 0;
        last = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.change_pulse) begin
                np++;
                if (np == 1) chk("chg_first_at", k, 1);
                else         chk("chg_gap", k - last, GAP);
                last = k;
            end
        end
        chk("chg_count", np, 4);
        chk("chg_credit0", bus.credit, 0);
        chk("chg_idle", bus.busy, 0);
        read_stock(2, sv);
        chk("stock2_after", sv, 4);

        // Both coins at 18: one accepted (20), half rejected
        repeat (9) coin1();
        bus.coin_one = 1'b1; bus.coin_half = 1'b1; step();
        bus.coin_one = 1'b0; bus.coin_half = 1'b0;
        chk("both_credit20", bus.credit, 20);
        chk("both_reject", bus.coin_reject, 1);
        do_refund();
        drain(np);
        chk("refund20_pulses", np, 20);
        chk("refund20_credit", bus.credit, 0);

        // Credit 19, coin_one rejected, coin_half fits
        repeat (9) coin1();
        coinh();
        chk("credit_19", bus.credit, 19);
        coin1();
        chk("over_reject", bus.coin_reject, 1);
        chk("over_credit19", bus.credit, 19);
        coinh();
        chk("max_credit20", bus.credit, 20);
        chk("max_no_reject", bus.coin_reject, 0);
        do_refund();
        drain(np);
        chk("refund_b_pulses", np, 20);

        // Insufficient funds, then drain stock1 (price 5)
        coin1();
        do_sel(3'b010);
        chk("funds_err", bus.err_funds, 1);
        chk("funds_no_empty", bus.err_empty, 0);
        chk("funds_credit2", bus.credit, 2);
        chk("funds_no_vend", bus.vend_valid, 0);
        coin1(); coinh();
        do_sel(3'b010);
        chk("vend_id1", bus.vend_id, 1);
        coin1();
        chk("vend_coin_reject", bus.coin_reject, 1);
        chk("vend_coin_credit", bus.credit, 5);
        do_ack();
        chk("item1_credit0", bus.credit, 0);
        for (int r = 0; r < 4; r++) begin
            coin1(); coin1(); coinh();
            do_sel(3'b010);
            do_ack();
        end
        read_stock(1, sv);
        chk("stock1_empty", sv, 0);
        do_sel(3'b001);
        chk("idle_sel_funds", bus.err_funds, 1);
        chk("idle_sel_busy", bus.busy, 0);
        do_sel(3'b110);
        chk("lowbit_empty", bus.err_empty, 1);
        chk("lowbit_no_funds", bus.err_funds, 0);
        coin1();
        do_sel(3'b010);
        chk("credit_sel_empty", bus.err_empty, 1);
        chk("empty_credit2", bus.credit, 2);
        do_refund();
        drain(np);
        chk("refund2_pulses", np, 2);

        // Inactivity auto-refund of 3
        coin1(); coinh();
        chk("credit_3", bus.credit, 3);
        repeat (999) step();
        chk("to_not_yet", bus.busy, 0);
        step();
        chk("to_fired", bus.busy, 1);
        drain(np);
        chk("to_pulses", np, 3);
        chk("to_credit0", bus.credit, 0);
        chk("to_idle", bus.busy, 0);

        // Asynchronous reset in the middle of a vend
        repeat (3) coin1();
        do_sel(3'b001);
        chk("pre_rst_valid", bus.vend_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.vend_valid, 0);
        chk("arst_credit", bus.credit, 0);
        chk("arst_busy", bus.busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        read_stock(0, sv);
        chk("arst_stock0", sv, 5);

        // fill_up ignored in CREDIT, honoured in IDLE
        coin1();
        bus.fill_up = 1'b1; step(); bus.fill_up = 1'b0;
        read_stock(1, sv);
        chk("fill_credit_ignored", sv, 5);
        do_refund();
        drain(np);
        bus.inq_id = '0;
        bus.fill_up = 1'b1; step(); bus.fill_up = 1'b0;
        step();
        chk("fill_stock0", bus.stock_q, 15);
        read_stock(1, sv);
        chk("fill_stock1", sv, 15);
        read_stock(2, sv);
        chk("fill_stock2", sv, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
